// File: rtl/dout_display.sv
// Output-bus display sink: latches a byte, converts it to decimal with a
// sequential double-dabble engine and drives sign plus three 7-seg digits.
module dout_display #(
    parameter bit SIGNED        = 1'b0,
    parameter bit BLANK_LEADING = 1'b1
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic [7:0] din,
    input  logic       dval,
    output logic       ready,
    output logic [6:0] hex0,
    output logic [6:0] hex1,
    output logic [6:0] hex2,
    output logic [6:0] hex3
);

    localparam logic [6:0] BLANK = 7'h7F;
    localparam logic [6:0] MINUS = 7'b0111111;

    typedef enum logic [1:0] {IDLE, CONVERT, UPDATE} state_t;

    state_t      state;
    state_t      state_nx;
    logic [7:0]  mag;
    logic [11:0] bcd;
    logic        sign;
    logic        pend;
    logic [7:0]  pend_data;
    logic [2:0]  cnt;

    logic [11:0] adj;
    logic [19:0] shifted;
    logic [7:0]  load_byte;
    logic [7:0]  load_mag;
    logic        load_sign;
    logic [3:0]  dig_h;
    logic [3:0]  dig_t;
    logic [3:0]  dig_o;

    function automatic logic [6:0] seg(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'b1000000;
            4'd1:    s = 7'b1111001;
            4'd2:    s = 7'b0100100;
            4'd3:    s = 7'b0110000;
            4'd4:    s = 7'b0011001;
            4'd5:    s = 7'b0010010;
            4'd6:    s = 7'b0000010;
            4'd7:    s = 7'b1111000;
            4'd8:    s = 7'b0000000;
            4'd9:    s = 7'b0010000;
            default: s = BLANK;
        endcase
        return s;
    endfunction

    always_comb begin
        adj[3:0]   = (bcd[3:0]   >= 4'd5) ? bcd[3:0]   + 4'd3 : bcd[3:0];
        adj[7:4]   = (bcd[7:4]   >= 4'd5) ? bcd[7:4]   + 4'd3 : bcd[7:4];
        adj[11:8]  = (bcd[11:8]  >= 4'd5) ? bcd[11:8]  + 4'd3 : bcd[11:8];
        shifted    = {adj, mag} << 1;
        // A byte arriving during UPDATE is newer than anything pending.
        load_byte  = (state == UPDATE && !dval) ? pend_data : din;
        load_sign  = SIGNED && load_byte[7];
        load_mag   = load_sign ? (~load_byte + 8'd1) : load_byte;
        dig_h      = bcd[11:8];
        dig_t      = bcd[7:4];
        dig_o      = bcd[3:0];
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (dval) state_nx = CONVERT;
            CONVERT: if (cnt == 3'd7) state_nx = UPDATE;
            UPDATE:  state_nx = (pend || dval) ? CONVERT : IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) state <= IDLE;
        else         state <= state_nx;
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            mag       <= '0;
            bcd       <= '0;
            sign      <= 1'b0;
            pend      <= 1'b0;
            pend_data <= '0;
            cnt       <= '0;
            ready     <= 1'b1;
            hex0      <= BLANK;
            hex1      <= BLANK;
            hex2      <= BLANK;
            hex3      <= BLANK;
        end else begin
            case (state)
                IDLE: begin
                    if (dval) begin
                        mag   <= load_mag;
                        sign  <= load_sign;
                        bcd   <= '0;
                        cnt   <= '0;
                        ready <= 1'b0;
                    end
                end
                CONVERT: begin
                    {bcd, mag} <= shifted;
                    cnt        <= cnt + 3'd1;
                    if (dval) begin
                        pend_data <= din;
                        pend      <= 1'b1;
                    end
                end
                UPDATE: begin
                    hex0 <= seg(dig_o);
                    hex1 <= (BLANK_LEADING && dig_h == 4'd0 && dig_t == 4'd0)
                            ? BLANK : seg(dig_t);
                    hex2 <= (BLANK_LEADING && dig_h == 4'd0)
                            ? BLANK : seg(dig_h);
                    hex3 <= sign ? MINUS : BLANK;
                    if (pend || dval) begin
                        mag   <= load_mag;
                        sign  <= load_sign;
                        bcd   <= '0;
                        cnt   <= '0;
                        pend  <= 1'b0;
                        ready <= 1'b0;
                    end else begin
                        ready <= 1'b1;
                    end
                end
                default: ready <= 1'b1;
            endcase
        end
    end

endmodule

// File: tb/tb_dout_display.sv
// Directed bench for dout_display: vector table over three parameter
// variants plus back-to-back and mid-conversion reset sequences.
module tb_dout_display;

    localparam logic [6:0] B  = 7'h7F;
    localparam logic [6:0] M  = 7'b0111111;
    localparam logic [6:0] D0 = 7'b1000000;
    localparam logic [6:0] D1 = 7'b1111001;
    localparam logic [6:0] D2 = 7'b0100100;
    localparam logic [6:0] D4 = 7'b0011001;
    localparam logic [6:0] D5 = 7'b0010010;
    localparam logic [6:0] D6 = 7'b0000010;
    localparam logic [6:0] D7 = 7'b1111000;
    localparam logic [6:0] D8 = 7'b0000000;

    logic       clk;
    logic       resetn;
    logic [7:0] din;
    logic       dval;
    logic       rdy [3];
    logic [6:0] hx  [3][4];

    int checks = 0;
    int errors = 0;

    // u0: unsigned/blanking, u1: signed/blanking, u2: unsigned/no blanking
    dout_display #(.SIGNED(1'b0), .BLANK_LEADING(1'b1)) u0 (
        .clk(clk), .resetn(resetn), .din(din), .dval(dval), .ready(rdy[0]),
        .hex0(hx[0][0]), .hex1(hx[0][1]), .hex2(hx[0][2]), .hex3(hx[0][3])
    );
    dout_display #(.SIGNED(1'b1), .BLANK_LEADING(1'b1)) u1 (
        .clk(clk), .resetn(resetn), .din(din), .dval(dval), .ready(rdy[1]),
        .hex0(hx[1][0]), .hex1(hx[1][1]), .hex2(hx[1][2]), .hex3(hx[1][3])
    );
    dout_display #(.SIGNED(1'b0), .BLANK_LEADING(1'b0)) u2 (
        .clk(clk), .resetn(resetn), .din(din), .dval(dval), .ready(rdy[2]),
        .hex0(hx[2][0]), .hex1(hx[2][1]), .hex2(hx[2][2]), .hex3(hx[2][3])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int         sel;
        logic [7:0] d;
        logic [6:0] e3, e2, e1, e0;
    } vec_t;

    vec_t v[10];

    task automatic chk(input string name, input logic [6:0] act,
                       input logic [6:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic pulse(input logic [7:0] d);
        din  = d;
        dval = 1'b1;
        @(negedge clk);
        dval = 1'b0;
    endtask

    initial begin
        int bad_rdy;
        int bad_hold;

        v[0] = '{0, 8'd0,   B, B,  B,  D0};
        v[1] = '{0, 8'd255, B, D2, D5, D5};
        v[2] = '{0, 8'd7,   B, B,  B,  D7};
        v[3] = '{0, 8'd100, B, D1, D0, D0};
        v[4] = '{1, 8'h80,  M, D1, D2, D8};
        v[5] = '{1, 8'hFF,  M, B,  B,  D1};
        v[6] = '{1, 8'h7F,  B, D1, D2, D7};
        v[7] = '{1, 8'h9C,  M, D1, D0, D0};
        v[8] = '{2, 8'd5,   B, D0, D0, D5};
        v[9] = '{2, 8'hFF,  B, D2, D5, D5};

        resetn = 1'b0;
        dval   = 1'b0;
        din    = 8'd0;
        repeat (2) @(negedge clk);
        for (int u = 0; u < 3; u++) begin
            for (int h = 0; h < 4; h++) chk("reset_hex", hx[u][h], B);
            chk("reset_ready", {6'd0, rdy[u]}, 7'd1);
        end

        resetn = 1'b1;
        repeat (20) @(negedge clk);
        for (int h = 0; h < 4; h++) chk("idle_hold_hex", hx[0][h], B);
        chk("idle_hold_ready", {6'd0, rdy[0]}, 7'd1);

        // back-to-back: 12 at E0, 34 at E3, 56 at E5
        bad_rdy  = 0;
        bad_hold = 0;
        pulse(8'd12);
        if (rdy[0] !== 1'b0) bad_rdy++;
        for (int k = 1; k <= 18; k++) begin
            @(negedge clk);
            if (k < 18 && rdy[0] !== 1'b0) bad_rdy++;
            if (k == 8) chk("b2b_pre_e9_hex0", hx[0][0], B);
            if (k >= 9 && k < 18 &&
                (hx[0][0] !== D2 || hx[0][1] !== D1 || hx[0][2] !== B))
                bad_hold++;
            if (k == 18) begin
                chk("b2b_56_hex0", hx[0][0], D6);
                chk("b2b_56_hex1", hx[0][1], D5);
                chk("b2b_56_hex2", hx[0][2], B);
                chk("b2b_56_ready", {6'd0, rdy[0]}, 7'd1);
            end
            if (k == 2) begin din = 8'd34; dval = 1'b1; end
            if (k == 3) dval = 1'b0;
            if (k == 4) begin din = 8'd56; dval = 1'b1; end
            if (k == 5) dval = 1'b0;
        end
        chk("b2b_ready_low", 7'(bad_rdy), 7'd0);
        chk("b2b_hold_12", 7'(bad_hold), 7'd0);

        // reset at E4 of a conversion of 200
        pulse(8'd200);
        repeat (3) @(negedge clk);
        resetn = 1'b0;
        @(negedge clk);
        chk("midrst_hex0", hx[0][0], B);
        chk("midrst_hex1", hx[0][1], B);
        chk("midrst_ready", {6'd0, rdy[0]}, 7'd1);
        resetn = 1'b1;
        repeat (12) @(negedge clk);
        chk("midrst_aborted_hex0", hx[0][0], B);
        pulse(8'd42);
        repeat (8) @(negedge clk);
        chk("midrst_42_early", hx[0][0], B);
        @(negedge clk);
        chk("midrst_42_hex0", hx[0][0], D2);
        chk("midrst_42_hex1", hx[0][1], D4);
        chk("midrst_42_hex2", hx[0][2], B);

        for (int i = 0; i < 10; i++) begin
            int s;
            s = v[i].sel;
            pulse(v[i].d);
            repeat (8) @(negedge clk);
            chk($sformatf("v%0d_busy", i), {6'd0, rdy[s]}, 7'd0);
            @(negedge clk);
            chk($sformatf("v%0d_hex3", i), hx[s][3], v[i].e3);
            chk($sformatf("v%0d_hex2", i), hx[s][2], v[i].e2);
            chk($sformatf("v%0d_hex1", i), hx[s][1], v[i].e1);
            chk($sformatf("v%0d_hex0", i), hx[s][0], v[i].e0);
            chk($sformatf("v%0d_ready", i), {6'd0, rdy[s]}, 7'd1);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/dout_display.md
# dout_display

Receiving end of the SoC output data bus. It latches a byte from the `dout`/`dval` pair and converts it to decimal with a sequential shift-add-3 (double-dabble) engine, one iteration per clock. It then drives four active-low 7-segment digits: sign plus three decimal digits. It sits between the `soc` outputs and the board's right four HEX displays.

## Interface
Parameters:
- `SIGNED`, default 0: 1 = interpret the byte as two's complement; 0 = unsigned.
- `BLANK_LEADING`, default 1: 1 = blank leading zero digits; 0 = show all three digits.

Ports:
- `clk` in 1: 50 MHz system clock; the block's only clock.
- `resetn` in 1: active-low reset, synchronous to `clk`.
- `din` in 8: data byte from `soc` `dout`.
- `dval` in 1: data valid from `soc`; level-sensitive.
- `ready` out 1: high when in IDLE with nothing pending.
- `hex0` out 7: ones digit.
- `hex1` out 7: tens digit.
- `hex2` out 7: hundreds digit.
- `hex3` out 7: sign digit.
- Segment encoding for all `hexN`: bit0=a … bit6=g, active-low.

## Operation
- States: IDLE, CONVERT, UPDATE. All outputs are registered.
- Reset (`resetn`=0 at a `clk` edge):
  - state=IDLE; pending cleared; iteration counter cleared.
  - `hex0..hex3` = 7'h7F (blank); `ready`=1.
  - Takes priority over every other event, including mid-CONVERT. An aborted conversion never reaches the displays.
- IDLE:
  - If `dval`=1, latch `din` and go to CONVERT with counter=0.
  - Latching stores the magnitude and the sign flag.
  - Magnitude: |din| if `SIGNED`=1 and din[7]=1 (two's complement negate, 9-bit safe; 8'h80 gives 128); otherwise din.
- CONVERT:
  - 8 iterations, counter 0..7.
  - Each iteration: add 3 to every BCD nibble that is ≥5, then shift {BCD[11:0], mag[7:0]} left by 1.
  - After iteration 7, go to UPDATE.
  - If `dval`=1 in any CONVERT or UPDATE cycle, capture `din` into a one-deep pending register and set pending. A newer capture overwrites an older one.
- UPDATE:
  - Encode the BCD result into `hex0..hex2`.
  - `hex3` = 7'b0111111 ('-') if the sign flag is set, else blank.
  - With `BLANK_LEADING`=1: hundreds is blank if 0; tens is blank if hundreds and tens are both 0; ones is always shown.
  - Next state: CONVERT, loading pending data and clearing pending, if pending is set; otherwise IDLE.
- Digit codes 0–9: 1000000, 1111001, 0100100, 0110000, 0011001, 0010010, 0000010, 1111000, 0000000, 0010000.
- Displays hold their value indefinitely while `dval`=0.
- `dval` held high continuously re-converts each pass. The displays are rewritten with identical values if `din` is constant.

## Timing
- Edge E0 samples `dval`=1 in IDLE.
- E1..E8 perform the 8 iterations.
- E9 (UPDATE) registers the new `hexN` values, so displays change exactly 9 clocks after the sampling edge.
- `ready` falls at E0 and rises at E9 if nothing is pending.
- Max throughput: one byte per 9 clocks with `dval` continuously high (UPDATE→CONVERT directly).
- A `dval` pulse present only during CONVERT/UPDATE is never lost: the most recent one is displayed.
- Reset asserted at any edge gives blank displays at that same edge. The first valid result after reset release appears ≥9 clocks after the first sampled `dval`.

## Test plan
- Reset: `resetn`=0 for 2 clocks → `hex0..3`=7'h7F and `ready`=1. Release reset with `dval`=0 for 20 clocks → outputs unchanged.
- Unsigned extremes (`SIGNED`=0, `BLANK_LEADING`=1):
  - din=8'd0 pulse → after 9 clocks `hex0`=1000000, `hex1`/`hex2`/`hex3`=7'h7F.
  - din=8'd255 → `hex2,hex1,hex0` = 2,5,5 (0100100, 0010010, 0010010).
  - din=8'd7 → only `hex0`=1111000 is lit.
- Signed (`SIGNED`=1):
  - din=8'h80 → `hex3`='-', digits 1,2,8.
  - din=8'hFF → '-', then `hex0`=1111001 with tens and hundreds blank.
  - din=8'h7F → no sign, digits 1,2,7.
- Back-to-back: pulse din=12 at E0, then din=34 at E3 and din=56 at E5.
  - → 12 is shown at E9.
  - → 34 is never shown.
  - → 56 is shown at E18.
  - → `ready` stays 0 from E0 to E18.
- Reset mid-operation: start din=200, assert `resetn`=0 at E4 for 1 clock → displays blank. The next `dval` with din=42 displays 4,2 exactly 9 clocks later.
- No blanking (`BLANK_LEADING`=0): din=5 → `hex2`,`hex1` = 1000000 and `hex0` = 0010010.
